// File: rtl/pipelined_adder.sv
`default_nettype none
// ============================================================================
//  Module      : pipelined_adder
//  Description : Parametrised two-operand adder split into STAGES equal
//                slices, one slice per pipeline stage, with the inter-slice
//                carry registered between stages. Valid/ready handshakes on
//                both sides; the whole pipe advances or stalls as one.
//                Optional macro PIPELINED_ADDER_SUB_EN adds the `sub` port
//                (a - b computed as a + ~b + 1).
//  Revision    : 1.0 - initial release
// ============================================================================
module pipelined_adder #(
    parameter int N      = 16,
    parameter int STAGES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
`ifdef PIPELINED_ADDER_SUB_EN
    input  logic         sub,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    // Slice width; N must be a multiple of STAGES.
    localparam int c_w = N / STAGES;

    logic         w_adv;
    logic         w_xfer;
    logic [N-1:0] w_b_eff;
    logic         w_c0;

    // The pipe moves only when the output slot is empty or being drained.
    assign w_adv    = ~out_valid | out_ready;
    assign in_ready = w_adv & ~rst;
    assign w_xfer   = in_valid & in_ready;

`ifdef PIPELINED_ADDER_SUB_EN
    // Subtraction folds into the adder: invert b and inject a carry of one.
    assign w_b_eff = sub ? ~b : b;
    assign w_c0    = sub;
`else
    assign w_b_eff = b;
    assign w_c0    = 1'b0;
`endif

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        // Low bit of the slice handled here, and how many operand bits
        // (this slice and everything above it) arrive at this stage.
        localparam int c_lo  = s * c_w;
        localparam int c_rem = N - c_lo;

        logic [c_rem-1:0]      w_a_in;
        logic [c_rem-1:0]      w_b_in;
        logic                  w_c_in;
        logic                  w_v_in;
        logic [c_w:0]          w_add;
        logic [c_lo+c_w-1:0]   psum_d;

        logic                  vld_q;
        logic                  cy_q;
        logic [c_lo+c_w-1:0]   psum_q;

        if (s == 0) begin : g_first
            assign w_a_in = a;
            assign w_b_in = w_b_eff;
            assign w_c_in = w_c0;
            assign w_v_in = w_xfer;
            assign psum_d = w_add[c_w-1:0];
        end else begin : g_next
            assign w_a_in = g_stage[s-1].g_skew.opa_q;
            assign w_b_in = g_stage[s-1].g_skew.opb_q;
            assign w_c_in = g_stage[s-1].cy_q;
            assign w_v_in = g_stage[s-1].vld_q;
            // Lower slices already computed travel along with the transaction.
            assign psum_d = {w_add[c_w-1:0], g_stage[s-1].psum_q};
        end

        // Slice adder: lowest remaining operand slice plus incoming carry.
        assign w_add = {1'b0, w_a_in[c_w-1:0]}
                     + {1'b0, w_b_in[c_w-1:0]}
                     + {{c_w{1'b0}}, w_c_in};

        // Stage register: valid bit, carry out and accumulated partial sum.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_q  <= 1'b0;
                cy_q   <= 1'b0;
                psum_q <= '0;
            end else if (w_adv) begin
                vld_q  <= w_v_in;
                cy_q   <= w_add[c_w];
                psum_q <= psum_d;
            end
        end

        if (s < STAGES - 1) begin : g_skew
            logic [c_rem-c_w-1:0] opa_q;
            logic [c_rem-c_w-1:0] opb_q;

            // Upper operand slices are delayed so they meet their own stage.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    opa_q <= '0;
                    opb_q <= '0;
                end else if (w_adv) begin
                    opa_q <= w_a_in[c_rem-1:c_w];
                    opb_q <= w_b_in[c_rem-1:c_w];
                end
            end
        end else begin : g_last
            logic ovf_d;
            logic ovf_q;

            // Signed overflow: operand signs agree but the result sign differs.
            assign ovf_d = (w_a_in[c_w-1] == w_b_in[c_w-1])
                         & (w_add[c_w-1] != w_a_in[c_w-1]);

            // Overflow flag is registered alongside the final slice.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (w_adv) begin
                    ovf_q <= ovf_d;
                end
            end

            assign out_valid = vld_q;
            assign sum       = psum_q;
            assign cout      = cy_q;
            assign ovf       = ovf_q;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipelined_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipelined_adder
//  Description : Scoreboard bench for pipelined_adder. Accepted operands push
//                an expected result from an arithmetic reference model; a
//                monitor pops and compares on every output handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_adder;

    localparam int N      = 16;
    localparam int STAGES = 4;

    typedef struct packed {
        logic [N-1:0] s;
        logic         c;
        logic         o;
    } res_t;

    logic         clk       = 1'b0;
    logic         rst       = 1'b0;
    logic         in_valid  = 1'b0;
    logic         out_ready = 1'b1;
    logic         sub       = 1'b0;
    logic [N-1:0] a         = '0;
    logic [N-1:0] b         = '0;
    logic         in_ready;
    logic         out_valid;
    logic [N-1:0] sum;
    logic         cout;
    logic         ovf;

    res_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    pipelined_adder #(.N(N), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
`ifdef PIPELINED_ADDER_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic res_t model(input logic [N-1:0] x, input logic [N-1:0] y, input logic s);
        int   ux, uy, sx, sy, r, sr;
        res_t e;
        ux  = int'(x);
        uy  = int'(y);
        sx  = int'($signed(x));
        sy  = int'($signed(y));
        r   = s ? ux - uy : ux + uy;
        sr  = s ? sx - sy : sx + sy;
        e.s = r[N-1:0];
        e.c = s ? (ux >= uy) : (r >= (1 << N));
        e.o = (sr > (1 << (N-1)) - 1) || (sr < -(1 << (N-1)));
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: pop/compare on output handshakes, watch stalls, push on input handshakes.
    initial begin : scoreboard
        res_t e;
        res_t cur;
        res_t held;
        logic stalled;
        stalled = 1'b0;
        held    = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stalled = 1'b0;
            end else begin
                cur = {sum, cout, ovf};
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_out: got 0x%0h want no result", cur);
                    end else begin
                        e = exp_q.pop_front();
                        check("result", 32'(cur), 32'(e));
                    end
                end
                if (out_valid && !out_ready) begin
                    check("stall_in_ready", 32'(in_ready), 32'd0);
                    if (stalled) check("stall_hold", 32'(cur), 32'(held));
                    held    = cur;
                    stalled = 1'b1;
                end else begin
                    stalled = 1'b0;
                end
                if (in_valid && in_ready) exp_q.push_back(model(a, b, sub));
            end
        end
    end

    // Single transaction into an idle pipe: measure latency and check the result.
    task automatic run_one(input logic [N-1:0] x, input logic [N-1:0] y);
        int   lat;
        res_t e;
        e        = model(x, y, sub);
        a        = x;
        b        = y;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat      = -1;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) begin
                lat = i;
                break;
            end
            tick();
        end
        check("latency", 32'(lat), 32'(STAGES - 1));
        check("dir_result", 32'({sum, cout, ovf}), 32'(e));
        tick();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "bench timed out");
    end

    initial begin : main
        logic [31:0] mask;

        // Reset state
        #1 rst = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum",       32'(sum),       32'd0);
        check("rst_cout",      32'(cout),      32'd0);
        check("rst_ovf",       32'(ovf),       32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd0);
        repeat (3) tick();
        rst = 1'b0;
        #1;
        check("in_ready_after_rst", 32'(in_ready), 32'd1);
        tick();

        // Directed carry/overflow cases
        run_one(16'hFFFF, 16'h0001);
        run_one(16'h7FFF, 16'h0001);
        run_one(16'h00FF, 16'h0001);

        // Back-to-back stream: four consecutive valid cycles
        mask = '0;
        for (int j = 0; j < 12; j++) begin
            if (j < 4) begin
                a        = 16'(j + 1);
                b        = 16'(j + 1);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (out_valid) mask[j] = 1'b1;
        end
        check("b2b_valid_mask", mask, 32'hF << (STAGES - 1));
        repeat (4) tick();

        // Back-pressure: stall the output for three cycles
        for (int j = 0; j < 4; j++) begin
            a        = 16'(16'h0100 * (j + 1));
            b        = 16'(j + 3);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        check("bp_first_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b0;
        #1;
        check("bp_in_ready", 32'(in_ready), 32'd0);
        repeat (3) tick();
        out_ready = 1'b1;
        repeat (8) tick();
        check("bp_no_loss", 32'(exp_q.size()), 32'd0);

        // Reset with transactions in flight
        for (int j = 0; j < 4; j++) begin
            a        = 16'(16'h1000 + j);
            b        = 16'(16'h0203 * (j + 1));
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        check("rst_mid_pre_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_mid_out_valid", 32'(out_valid), 32'd0);
        check("rst_mid_sum",       32'(sum),       32'd0);
        check("rst_mid_in_ready",  32'(in_ready),  32'd0);
        exp_q.delete();
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_mid_in_ready_after", 32'(in_ready), 32'd1);
        repeat (8) tick();
        run_one(16'h1234, 16'h1111);
        check("post_rst_sum", 32'(sum), 32'h2345);

`ifdef PIPELINED_ADDER_SUB_EN
        sub = 1'b1;
        run_one(16'h0005, 16'h0007);
        run_one(16'h8000, 16'h0001);
        sub = 1'b0;
`endif

        // Randomised traffic with random back-pressure
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            a         = 16'($urandom);
            b         = 16'($urandom);
`ifdef PIPELINED_ADDER_SUB_EN
            sub       = 1'($urandom_range(0, 1));
`endif
            tick();
        end

        // Drain
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 50 && (exp_q.size() != 0 || out_valid); i++) tick();
        check("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
